fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `datapath`. It owns the fetch PC, issues read requests to a fixed one-cycle-latency instruction memory, and buffers returned words in a small in-order queue. It presents each instruction and its PC to the datapath with a valid/ready handshake, and flushes and refetches on a branch/jump redirect from the datapath.

---
 rtl/cpu_defs.sv | 13 +
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_queue.sv | 67 ++++++
 rtl/fetch_unit.sv | 74 +++++++
 tb/tb_fetch_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Constants and payload types shared by the fetch stage and the datapath.
// PC arithmetic is modulo 2^ADDR_W throughout.
package cpu_defs;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [ADDR_W-1:0] PC_INC   = 16'd4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect in, instruction-memory request/response, instruction handshake out.
// master = fetch unit, slave = datapath/memory side.
interface fetch_unit_if;
    import cpu_defs::*;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  redirect, redirect_pc, mem_rdata, instr_ready,
        output mem_req, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect, redirect_pc, mem_rdata, instr_ready,
        input  mem_req, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue with push, pop, flush; head outputs come straight from flops.
// Flush wins over push/pop; caller guarantees no push when full and no pop when empty.
module fetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             push_dat,
    output fetch_entry_t             head_dat,
    output logic                     head_vld,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign head_vld = (count_q != '0);
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one-cycle-latency reads, queues returned words for the datapath.
// Issue is throttled so queued + in-flight never exceeds DEPTH; a redirect flushes and refetches at once.
module fetch_unit
    import cpu_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;

    logic [CW-1:0]     q_count;
    logic [CW:0]       occupancy;
    logic              issue_ok;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              q_push, q_pop, head_vld;
    fetch_entry_t      push_dat, head_dat;

    // A same-cycle pop is deliberately not credited, keeping overflow impossible.
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
    assign issue_ok  = occupancy < (CW+1)'(DEPTH);

    always_comb begin
        req           = !reset && (bus.redirect || issue_ok);
        addr          = bus.redirect ? bus.redirect_pc : fetch_pc_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = req;
        if (req) begin
            fetch_pc_d    = addr + PC_INC;
            inflight_pc_d = addr;
        end
        q_push   = inflight_q && !bus.redirect;
        q_pop    = head_vld && bus.instr_ready && !bus.redirect;
        push_dat = '{pc: inflight_pc_q, instr: bus.mem_rdata};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push     (q_push),
        .pop      (q_pop),
        .flush    (bus.redirect),
        .push_dat (push_dat),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .count    (q_count)
    );

    assign bus.mem_req     = req;
    assign bus.mem_addr    = addr;
    assign bus.instr_valid = head_vld;
    assign bus.instr       = head_dat.instr;
    assign bus.instr_pc    = head_dat.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random stimulus for fetch_unit against a queue-based behavioural model.
module tb_fetch_unit;
    import cpu_defs::*;

    localparam int DEPTH = 4;
    localparam logic [15:0] KEY = 16'hA5A5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fetch_unit_if fif ();

    fetch_unit #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (fif.master)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_fetch_pc;
    logic [15:0] m_inflight_pc;
    bit          m_inflight;
    bit          model_ok = 1'b0;

    logic        cur_req, cur_vld;
    logic [15:0] cur_addr, cur_instr, cur_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance model and memory.
    task automatic step(input bit rst, input bit redir, input logic [15:0] rpc, input bit rdy);
        logic        exp_req;
        logic [15:0] exp_addr;
        bit          exp_vld;
        reset           = rst;
        fif.redirect    = redir;
        fif.redirect_pc = rpc;
        fif.instr_ready = rdy;
        #5;
        cur_req   = fif.mem_req;
        cur_addr  = fif.mem_addr;
        cur_vld   = fif.instr_valid;
        cur_instr = fif.instr;
        cur_pc    = fif.instr_pc;
        exp_req   = !rst && (redir || (mq.size() + int'(m_inflight) < DEPTH));
        exp_addr  = redir ? rpc : m_fetch_pc;
        exp_vld   = mq.size() > 0;
        if (model_ok) begin
            chk("mem_req", cur_req, exp_req);
            if (exp_req) chk("mem_addr", cur_addr, exp_addr);
            chk("instr_valid", cur_vld, exp_vld);
            chk("instr", cur_instr, exp_vld ? mq[0].ins : 16'h0);
            chk("instr_pc", cur_pc, exp_vld ? mq[0].pc : 16'h0);
        end
        if (rst) begin
            model_ok   = 1'b1;
            m_fetch_pc = RESET_PC;
            m_inflight = 1'b0;
            mq.delete();
        end else begin
            if (redir) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && rdy) mq.delete(0);
                if (m_inflight) mq.push_back('{m_inflight_pc, m_inflight_pc ^ KEY});
            end
            if (exp_req) begin
                m_inflight_pc = exp_addr;
                m_fetch_pc    = exp_addr + 16'd4;
            end
            m_inflight = exp_req;
        end
        @(posedge clock);
        #1;
        fif.mem_rdata = cur_req ? (cur_addr ^ KEY) : 16'($urandom);
    endtask

    initial begin
        logic [15:0] seen[$];
        int          nreq;
        logic [15:0] first_req;
        bit          got_first;

        fif.redirect    = 1'b0;
        fif.redirect_pc = '0;
        fif.instr_ready = 1'b0;
        fif.mem_rdata   = '0;
        @(posedge clock);
        #1;

        // Reset values
        step(1, 0, 16'h0, 0);
        step(1, 0, 16'h0, 0);
        chk("rst_mem_req", cur_req, 0);
        chk("rst_instr_valid", cur_vld, 0);
        chk("rst_instr", cur_instr, 0);
        chk("rst_instr_pc", cur_pc, 0);

        // Cold start, instr_ready high
        step(0, 0, 16'h0, 1);
        chk("cold_addr0", cur_addr, 16'h0000);
        chk("cold_vld0", cur_vld, 0);
        step(0, 0, 16'h0, 1);
        chk("cold_addr1", cur_addr, 16'h0004);
        chk("cold_vld1", cur_vld, 0);
        step(0, 0, 16'h0, 1);
        chk("cold_addr2", cur_addr, 16'h0008);
        chk("cold_vld2", cur_vld, 1);
        chk("cold_pc2", cur_pc, 16'h0000);
        chk("cold_instr2", cur_instr, 16'hA5A5);
        step(0, 0, 16'h0, 1);
        chk("steady_pc3", cur_pc, 16'h0004);

        // Backpressure from reset
        step(1, 0, 16'h0, 0);
        nreq = 0;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 16'h0, 0);
            if (cur_req) begin
                nreq++;
                seen.push_back(cur_addr);
            end
        end
        chk("bp_nreq", nreq, 4);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("bp_req_addr", seen[i], 16'(4 * i));
        chk("bp_head_pc", cur_pc, 16'h0000);
        chk("bp_head_instr", cur_instr, 16'hA5A5);

        // Release: pops in order, fetch resumes after the queue drains a slot
        seen.delete();
        got_first = 1'b0;
        first_req = '0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 16'h0, 1);
            if (cur_vld) seen.push_back(cur_pc);
            if (cur_req && !got_first) begin
                got_first = 1'b1;
                first_req = cur_addr;
            end
        end
        chk("rel_npop", seen.size() >= 4, 1);
        for (int i = 0; i < 4 && i < seen.size(); i++) chk("rel_pop_pc", seen[i], 16'(4 * i));
        chk("rel_resume_addr", first_req, 16'h0010);

        // Redirect with a response in flight
        step(0, 1, 16'h00F0, 1);
        chk("rd_req", cur_req, 1);
        chk("rd_addr", cur_addr, 16'h00F0);
        step(0, 0, 16'h0, 1);
        chk("rd_n1_vld", cur_vld, 0);
        step(0, 0, 16'h0, 1);
        chk("rd_n2_vld", cur_vld, 1);
        chk("rd_n2_pc", cur_pc, 16'h00F0);
        chk("rd_n2_instr", cur_instr, 16'h00F0 ^ KEY);
        step(0, 0, 16'h0, 1);
        chk("rd_n3_pc", cur_pc, 16'h00F4);

        // Redirect with the queue full and instr_ready high
        step(1, 0, 16'h0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 0);
        step(0, 1, 16'h0200, 1);
        chk("full_rd_vld", cur_vld, 1);
        chk("full_rd_addr", cur_addr, 16'h0200);
        step(0, 0, 16'h0, 1);
        chk("full_n1_vld", cur_vld, 0);
        step(0, 0, 16'h0, 1);
        chk("full_n2_pc", cur_pc, 16'h0200);

        // Wrap-around
        step(0, 1, 16'hFFFC, 1);
        seen.delete();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 16'h0, 1);
            if (cur_vld) seen.push_back(cur_pc);
        end
        chk("wrap_n", seen.size() >= 3, 1);
        if (seen.size() >= 3) begin
            chk("wrap_pc0", seen[0], 16'hFFFC);
            chk("wrap_pc1", seen[1], 16'h0000);
            chk("wrap_pc2", seen[2], 16'h0004);
        end

        // Reset mid-stream with three entries queued
        step(1, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 0);
        chk("mr_pre_vld", cur_vld, 1);
        step(1, 1, 16'h0300, 0);
        chk("mr_rst_req", cur_req, 0);
        step(1, 0, 16'h0, 0);
        chk("mr_after_vld", cur_vld, 0);
        chk("mr_after_req", cur_req, 0);
        step(0, 0, 16'h0, 1);
        chk("mr_restart_req", cur_req, 1);
        chk("mr_restart_addr", cur_addr, 16'h0000);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) == 0,
                 16'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
